capture_ctrl: RTL and testbench

Parametrised trigger-and-capture controller for the DSO digital core: it generates the ADC/RAM sample clock, writes decimated samples into a circular capture RAM and qualifies a selectable trigger edge. It stops after a programmable number of post-trigger samples, then hands the RAM address bus to the dump logic for readout. It generalises the fixed 2-trigger, 512-deep capture path: source count, depth, decimation width and auto-timeout are all parameters, and it adds normal/auto modes, abort and read pass-through.

---
 rtl/capture_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// Trigger-and-capture controller: free-running adc_clk, decimated circular RAM writes, trigger qualify, post-count stop.
// Latency: trigger edge accepted 3 clk after input change; capture_done rises 1 clk after final post-trigger write.
// Backpressure: none; RAM bus is owned by write logic while capturing and passed to rd_* in IDLE/DONE.
module capture_ctrl #(
  parameter int ADDR_W   = 9,
  parameter int NUM_TRIG = 2,
  parameter int SEL_W    = 1,
  parameter int DEC_W    = 4,
  parameter int AUTO_TO  = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_TRIG-1:0] trig,
  input  logic [SEL_W-1:0]    trig_sel,
  input  logic                trig_edge,
  input  logic                auto_mode,
  input  logic [ADDR_W-1:0]   trig_pos,
  input  logic [DEC_W-1:0]    decimator,
  input  logic                arm,
  input  logic                abort,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                adc_clk,
  output logic                en,
  output logic                we,
  output logic [ADDR_W-1:0]   addr,
  output logic                capture_done,
  output logic                triggered,
  output logic [ADDR_W-1:0]   trig_addr
);

  // Decimation counter must hold 2^decimator - 1 for the largest exponent.
  localparam int DCW  = (1 << DEC_W) - 1;
  localparam int TO_W = $clog2(AUTO_TO + 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(AUTO_TO - 1);
  localparam logic [ADDR_W:0]   PRE_FULL = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q,     state_d;
  logic              adc_clk_q,   adc_clk_d;
  logic [DCW-1:0]    dec_cnt_q,   dec_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W:0]   pre_cnt_q,   pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q,  post_cnt_d;
  logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
  logic              triggered_q, triggered_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;

  logic sync1_q, sync2_q, sync3_q, edge_q;
  logic trig_mux;
  logic fire;

  logic              slot;
  logic              wr_mode;
  logic              strobe;
  logic              arm_go;
  logic [DCW-1:0]    dec_lim;
  logic [ADDR_W:0]   pre_target;

  // A sample slot is the half of the adc_clk period where adc_clk is high.
  assign slot       = adc_clk_q;
  assign wr_mode    = (state_q == S_ARM) || (state_q == S_WAIT) || (state_q == S_POST);
  assign strobe     = wr_mode && slot && (dec_cnt_q == '0);
  assign arm_go     = arm && !abort;
  assign dec_lim    = ~({DCW{1'b1}} << decimator);
  assign pre_target = PRE_FULL - {1'b0, trig_pos};

  // Select the trigger source; out-of-range selects give a constant low.
  always_comb begin
    trig_mux = 1'b0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      if (trig_sel == SEL_W'(i)) trig_mux = trig[i];
    end
  end

  // Two-flop synchronizer followed by a registered edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= trig_mux;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= trig_edge ? (sync2_q & ~sync3_q) : (~sync2_q & sync3_q);
    end
  end

  // Next-state logic for the capture FSM and its counters.
  always_comb begin
    state_d     = state_q;
    adc_clk_d   = ~adc_clk_q;
    dec_cnt_d   = dec_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    to_cnt_d    = to_cnt_q;
    triggered_d = triggered_q;
    trig_addr_d = trig_addr_q;
    fire        = 1'b0;

    if (slot) dec_cnt_d = (dec_cnt_q >= dec_lim) ? '0 : dec_cnt_q + 1'b1;
    if (strobe) wr_ptr_d = wr_ptr_q + 1'b1;

    case (state_q)
      S_ARM: begin
        if (strobe) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          if (pre_cnt_q + 1'b1 == pre_target) begin
            state_d  = S_WAIT;
            to_cnt_d = '0;
          end
        end
      end
      S_WAIT: begin
        // Saturate so a late auto_mode enable still times out promptly.
        if (slot && to_cnt_q != TO_LAST) to_cnt_d = to_cnt_q + 1'b1;
        fire = edge_q || (auto_mode && slot && (to_cnt_q == TO_LAST));
        if (fire) begin
          triggered_d = 1'b1;
          post_cnt_d  = '0;
          if (trig_pos == '0) begin
            state_d     = S_DONE;
            // Last written address: this cycle's write if any, else the previous one.
            trig_addr_d = strobe ? wr_ptr_q : wr_ptr_q - 1'b1;
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (strobe) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_q + 1'b1 == trig_pos) begin
            state_d     = S_DONE;
            trig_addr_d = wr_ptr_q;
          end
        end
      end
      default: ;
    endcase

    if (arm_go) begin
      state_d     = S_ARM;
      dec_cnt_d   = '0;
      wr_ptr_d    = '0;
      pre_cnt_d   = '0;
      post_cnt_d  = '0;
      triggered_d = 1'b0;
    end

    if (abort) begin
      state_d     = S_IDLE;
      triggered_d = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      adc_clk_q   <= 1'b0;
      dec_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      to_cnt_q    <= '0;
      triggered_q <= 1'b0;
      trig_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      adc_clk_q   <= adc_clk_d;
      dec_cnt_q   <= dec_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      to_cnt_q    <= to_cnt_d;
      triggered_q <= triggered_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  // RAM bus mux: write logic while capturing, dump logic pass-through otherwise.
  always_comb begin
    en   = rd_en;
    we   = 1'b0;
    addr = rd_addr;
    if (wr_mode) begin
      en   = strobe;
      we   = strobe;
      addr = wr_ptr_q;
    end
  end

  assign adc_clk      = adc_clk_q;
  assign capture_done = (state_q == S_DONE);
  assign triggered    = triggered_q;
  assign trig_addr    = trig_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a 16-deep RAM and an 8-slot auto timeout.
// Outputs sampled at the falling clk edge; inputs driven right after sampling.
// Each scenario task checks its own hand-computed expectations.
module tb_capture_ctrl;
  localparam int AW  = 4;
  localparam int NT  = 2;
  localparam int SW  = 1;
  localparam int DW  = 4;
  localparam int ATO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NT-1:0] trig;
  logic [SW-1:0] trig_sel;
  logic          trig_edge;
  logic          auto_mode;
  logic [AW-1:0] trig_pos;
  logic [DW-1:0] decimator;
  logic          arm;
  logic          abort;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          adc_clk;
  logic          en;
  logic          we;
  logic [AW-1:0] addr;
  logic          capture_done;
  logic          triggered;
  logic [AW-1:0] trig_addr;

  int errors = 0;
  int checks = 0;

  capture_ctrl #(
    .ADDR_W(AW), .NUM_TRIG(NT), .SEL_W(SW), .DEC_W(DW), .AUTO_TO(ATO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .trig_sel(trig_sel),
    .trig_edge(trig_edge), .auto_mode(auto_mode), .trig_pos(trig_pos),
    .decimator(decimator), .arm(arm), .abort(abort), .rd_en(rd_en),
    .rd_addr(rd_addr), .adc_clk(adc_clk), .en(en), .we(we), .addr(addr),
    .capture_done(capture_done), .triggered(triggered), .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  task automatic pulse_arm();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  // Runs a capture from the current cycle (cycle 0 = first cycle in ARM),
  // toggling trig[idx] at the given cycles, and tallies writes.
  task automatic run_capture(input int r1, input int d1, input int r2, input int idx,
                             input logic act, input int budget,
                             output int pre, output int post, output int done_cyc,
                             output int last_wr);
    pre = 0; post = 0; done_cyc = -1; last_wr = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (capture_done) begin
        done_cyc = cyc;
        break;
      end
      if (we) begin
        if (triggered) post++; else pre++;
        last_wr = cyc;
      end
      if (cyc == r1 || cyc == r2) trig[idx] = act;
      if (cyc == d1) trig[idx] = ~act;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 7;
    if (adc_clk !== 1'b0)      begin errors++; $display("FAIL reset_adc_clk: got %0b want 0", adc_clk); end
    if (en !== 1'b0)           begin errors++; $display("FAIL reset_en: got %0b want 0", en); end
    if (we !== 1'b0)           begin errors++; $display("FAIL reset_we: got %0b want 0", we); end
    if (addr !== 4'd0)         begin errors++; $display("FAIL reset_addr: got %0d want 0", addr); end
    if (capture_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", capture_done); end
    if (triggered !== 1'b0)    begin errors++; $display("FAIL reset_triggered: got %0b want 0", triggered); end
    if (trig_addr !== 4'd0)    begin errors++; $display("FAIL reset_trig_addr: got %0d want 0", trig_addr); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_capture_edge();
    int pre, post, dc, lw;
    trig_pos = 4'd4; decimator = '0; auto_mode = 1'b0; trig_sel = '0; trig_edge = 1'b1;
    pulse_arm();
    run_capture(30, -1, -1, 0, 1'b1, 200, pre, post, dc, lw);
    trig[0] = 1'b0;
    checks += 5;
    if (pre !== 17)           begin errors++; $display("FAIL edge_pre_writes: got %0d want 17", pre); end
    if (post !== 4)           begin errors++; $display("FAIL edge_post_writes: got %0d want 4", post); end
    if (dc !== lw + 1)        begin errors++; $display("FAIL edge_done_timing: done at %0d want %0d", dc, lw + 1); end
    if (trig_addr !== 4'd4)   begin errors++; $display("FAIL edge_trig_addr: got %0d want 4", trig_addr); end
    if (triggered !== 1'b1)   begin errors++; $display("FAIL edge_triggered: got %0b want 1", triggered); end
  endtask

  task automatic test_decimation();
    int wc[5];
    int n, bad, first;
    decimator = 4'd3; trig_pos = 4'd4;
    pulse_arm();
    n = 0;
    for (int cyc = 0; cyc < 120 && n < 5; cyc++) begin
      if (we) begin wc[n] = cyc; n++; end
      if (n < 5) @(negedge clk);
    end
    bad = 0;
    for (int i = 1; i < 5; i++) if (n < 5 || wc[i] - wc[i-1] != 16) bad++;
    checks += 2;
    if (n < 5 || wc[0] > 1) begin errors++; $display("FAIL dec_first_write: got n=%0d first=%0d want first<=1", n, wc[0]); end
    if (bad != 0)           begin errors++; $display("FAIL dec_interval: %0d intervals off, want all 16 clk", bad); end
    // Re-arm partway through a decimation period: count must restart.
    repeat (5) @(negedge clk);
    pulse_arm();
    first = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (we) begin first = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (first < 0 || first > 1) begin errors++; $display("FAIL dec_restart: first write at %0d want <=1", first); end
    pulse_abort();
    decimator = '0;
  endtask

  task automatic test_auto();
    int pre, post, slots;
    bit done_seen;
    auto_mode = 1'b1; trig_pos = 4'd4;
    pulse_arm();
    pre = 0; post = 0; slots = 0; done_seen = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (capture_done) begin done_seen = 1; break; end
      if (!triggered && adc_clk && pre >= 12) slots++;
      if (we) begin if (triggered) post++; else pre++; end
      @(negedge clk);
    end
    auto_mode = 1'b0;
    checks += 4;
    if (slots !== 8)                     begin errors++; $display("FAIL auto_slots: got %0d want 8", slots); end
    if (pre !== 20)                      begin errors++; $display("FAIL auto_pre_writes: got %0d want 20", pre); end
    if (post !== 4 || !done_seen)        begin errors++; $display("FAIL auto_post_writes: got %0d done=%0b want 4 done=1", post, done_seen); end
    if (trig_addr !== 4'd7)              begin errors++; $display("FAIL auto_trig_addr: got %0d want 7", trig_addr); end
  endtask

  task automatic test_arm_edge_ignored();
    int pre, post, dc, lw;
    trig_pos = 4'd4;
    pulse_arm();
    run_capture(2, 6, 40, 0, 1'b1, 200, pre, post, dc, lw);
    trig[0] = 1'b0;
    checks += 3;
    if (pre !== 22)         begin errors++; $display("FAIL armedge_pre_writes: got %0d want 22", pre); end
    if (post !== 4)         begin errors++; $display("FAIL armedge_post_writes: got %0d want 4", post); end
    if (trig_addr !== 4'd9) begin errors++; $display("FAIL armedge_trig_addr: got %0d want 9", trig_addr); end
  endtask

  task automatic test_trig_pos_zero();
    int pre, post, dc, lw;
    // Falling edge on source 1; hold it high first so the synchronizer settles.
    trig_sel = 1'b1; trig_edge = 1'b0; trig[1] = 1'b1;
    repeat (4) @(negedge clk);
    trig_pos = '0;
    pulse_arm();
    run_capture(40, -1, -1, 1, 1'b0, 200, pre, post, dc, lw);
    checks += 5;
    if (dc !== 44)          begin errors++; $display("FAIL tp0_done_cycle: got %0d want 44", dc); end
    if (pre !== 22)         begin errors++; $display("FAIL tp0_pre_writes: got %0d want 22", pre); end
    if (post !== 0)         begin errors++; $display("FAIL tp0_post_writes: got %0d want 0", post); end
    if (trig_addr !== 4'd5) begin errors++; $display("FAIL tp0_trig_addr: got %0d want 5", trig_addr); end
    if (triggered !== 1'b1) begin errors++; $display("FAIL tp0_triggered: got %0b want 1", triggered); end
    trig_sel = '0; trig_edge = 1'b1;
  endtask

  task automatic test_abort_readout();
    int post, wcount;
    bit found, done_seen;
    trig_pos = 4'd8;
    pulse_arm();
    post = 0; found = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc == 30) trig[0] = 1'b1;
      if (we && triggered) post++;
      if (triggered && post == 2 && !we) begin found = 1; break; end
      @(negedge clk);
    end
    // In POST the read port is ignored: bus shows the write pointer (19 mod 16).
    rd_en = 1'b1; rd_addr = 4'd5;
    #1;
    checks += 2;
    if (!found)                                  begin errors++; $display("FAIL abort_reach_post: got found=0 want 1"); end
    if (en !== 1'b0 || we !== 1'b0 || addr !== 4'd3) begin errors++; $display("FAIL post_rd_ignored: got en=%0b we=%0b addr=%0d want 0 0 3", en, we, addr); end
    rd_en = 1'b0; rd_addr = '0; trig[0] = 1'b0;
    pulse_abort();
    checks += 2;
    if (capture_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b want 0", capture_done); end
    if (triggered !== 1'b0)    begin errors++; $display("FAIL abort_triggered: got %0b want 0", triggered); end
    wcount = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (we) wcount++;
      @(negedge clk);
    end
    checks++;
    if (wcount !== 0) begin errors++; $display("FAIL abort_idle_writes: got %0d want 0", wcount); end
    // Fresh auto capture to DONE, then read pass-through.
    auto_mode = 1'b1; trig_pos = 4'd2;
    pulse_arm();
    done_seen = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (capture_done) begin done_seen = 1; break; end
      @(negedge clk);
    end
    auto_mode = 1'b0;
    rd_en = 1'b1; rd_addr = 4'd5;
    #1;
    checks += 2;
    if (!done_seen)                                   begin errors++; $display("FAIL readout_done: got 0 want 1"); end
    if (en !== 1'b1 || we !== 1'b0 || addr !== 4'd5)  begin errors++; $display("FAIL readout_pass: got en=%0b we=%0b addr=%0d want 1 0 5", en, we, addr); end
    rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic test_async_reset();
    bit trg_seen;
    auto_mode = 1'b1; trig_pos = 4'd8;
    pulse_arm();
    trg_seen = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (triggered) begin trg_seen = 1; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks += 2;
    if (!trg_seen)          begin errors++; $display("FAIL arst_reach_post: got 0 want 1"); end
    if (trig_addr !== 4'd7) begin errors++; $display("FAIL arst_prior_trig_addr: got %0d want 7", trig_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks += 7;
    if (adc_clk !== 1'b0)      begin errors++; $display("FAIL arst_adc_clk: got %0b want 0", adc_clk); end
    if (en !== 1'b0)           begin errors++; $display("FAIL arst_en: got %0b want 0", en); end
    if (we !== 1'b0)           begin errors++; $display("FAIL arst_we: got %0b want 0", we); end
    if (addr !== 4'd0)         begin errors++; $display("FAIL arst_addr: got %0d want 0", addr); end
    if (capture_done !== 1'b0) begin errors++; $display("FAIL arst_done: got %0b want 0", capture_done); end
    if (triggered !== 1'b0)    begin errors++; $display("FAIL arst_triggered: got %0b want 0", triggered); end
    if (trig_addr !== 4'd0)    begin errors++; $display("FAIL arst_trig_addr: got %0d want 0", trig_addr); end
    auto_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; trig = '0; trig_sel = '0; trig_edge = 1'b1; auto_mode = 1'b0;
    trig_pos = '0; decimator = '0; arm = 1'b0; abort = 1'b0; rd_en = 1'b0; rd_addr = '0;
    test_reset();
    test_capture_edge();
    test_decimation();
    test_auto();
    test_arm_edge_ignored();
    test_trig_pos_zero();
    test_abort_readout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
